// File: rtl/mem_arbiter_nport_if.sv
// Request, response and adapter beat signals of the N-port memory arbiter.
// slave = arbiter side; master = requesters plus AHB adapter side.
interface mem_arbiter_nport_if #(
    parameter int NUM_PORTS  = 4,
    parameter int BLOCK_SIZE = 32
);
    logic [NUM_PORTS-1:0]              req_valid;
    logic [NUM_PORTS-1:0]              req_write;
    logic [NUM_PORTS-1:0]              req_single;
    logic [NUM_PORTS*32-1:0]           req_addr;
    logic [NUM_PORTS*BLOCK_SIZE*8-1:0] req_wdata;
    logic [NUM_PORTS-1:0]              grant;
    logic [NUM_PORTS-1:0]              resp_done;
    logic [BLOCK_SIZE*8-1:0]           resp_rdata;
    logic [31:0]                       addr;
    logic                              write;
    logic [31:0]                       wdata;
    logic [1:0]                        transfer;
    logic [31:0]                       rdata;
    logic                              ready;

    modport slave (
        input  req_valid, req_write, req_single, req_addr, req_wdata, rdata, ready,
        output grant, resp_done, resp_rdata, addr, write, wdata, transfer
    );

    modport master (
        output req_valid, req_write, req_single, req_addr, req_wdata, rdata, ready,
        input  grant, resp_done, resp_rdata, addr, write, wdata, transfer
    );
endinterface

// File: rtl/mem_arbiter_nport.sv
// N-port arbiter onto one AHB adapter: first beat 1 cycle after sampling, resp_done 1 cycle after last beat.
// Adapter backpressure via ready stalls the beat in place; requesters wait on req_valid until resp_done.
module mem_arbiter_nport #(
    parameter int NUM_PORTS  = 4,
    parameter int BLOCK_SIZE = 32,
    parameter int ARB_MODE   = 0
) (
    input logic                  clk,
    input logic                  rst,
    mem_arbiter_nport_if.slave   bus
);
    localparam int WORDS  = BLOCK_SIZE / 4;
    localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int LINE_W = BLOCK_SIZE * 8;
    localparam logic [31:0]       BLOCK_MASK = ~(32'(BLOCK_SIZE) - 32'd1);
    localparam logic [31:0]       WORD_MASK  = ~32'd3;
    localparam logic [PORT_W-1:0] LAST_PORT  = PORT_W'(NUM_PORTS - 1);
    localparam logic [BEAT_W-1:0] LAST_WORD  = BEAT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t               state, stateNext;
    logic [PORT_W-1:0]    winner, rrPtr, startPtr, pick;
    logic [NUM_PORTS-1:0] ownerOneHot;
    logic                 anyReq, lastBeat;
    logic [BEAT_W-1:0]    beat;
    logic [31:0]          baseAddr, pickAddr;
    logic                 wrLatch, singleLatch;
    logic [LINE_W-1:0]    wdLatch, lineBuf;

    // Search in descending offset so the port nearest startPtr is the final assignment.
    always_comb begin
        startPtr = (ARB_MODE == 1) ? rrPtr : '0;
        pick     = '0;
        anyReq   = |bus.req_valid;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.req_valid[(int'(startPtr) + i) % NUM_PORTS])
                pick = PORT_W'((int'(startPtr) + i) % NUM_PORTS);
        end
        pickAddr = bus.req_addr[int'(pick)*32 +: 32];
    end

    assign lastBeat = singleLatch ? (beat == '0) : (beat == LAST_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext       = state;
        ownerOneHot     = NUM_PORTS'(1) << winner;
        bus.grant       = '0;
        bus.resp_done   = '0;
        bus.transfer    = 2'b00;
        bus.addr        = baseAddr + (32'(beat) << 2);
        bus.write       = wrLatch;
        bus.wdata       = wdLatch[{beat, 5'b0} +: 32];
        bus.resp_rdata  = lineBuf;
        case (state)
            IDLE: begin
                if (anyReq) stateNext = XFER;
            end
            XFER: begin
                bus.grant    = ownerOneHot;
                bus.transfer = (beat == '0) ? 2'b10 : 2'b11;
                if (bus.ready && lastBeat) stateNext = DONE;
            end
            DONE: begin
                bus.grant     = ownerOneHot;
                bus.resp_done = ownerOneHot;
                stateNext     = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner      <= '0;
            rrPtr       <= '0;
            beat        <= '0;
            baseAddr    <= '0;
            wrLatch     <= 1'b0;
            singleLatch <= 1'b0;
            wdLatch     <= '0;
            lineBuf     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        winner      <= pick;
                        wrLatch     <= bus.req_write[pick];
                        singleLatch <= bus.req_single[pick];
                        wdLatch     <= bus.req_wdata[int'(pick)*LINE_W +: LINE_W];
                        baseAddr    <= pickAddr & (bus.req_single[pick] ? WORD_MASK : BLOCK_MASK);
                        beat        <= '0;
                    end
                end
                XFER: begin
                    if (bus.ready) begin
                        if (!wrLatch) lineBuf[{beat, 5'b0} +: 32] <= bus.rdata;
                        if (!lastBeat) beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    rrPtr <= (winner == LAST_PORT) ? '0 : winner + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Directed bench: a fixed-priority and a round-robin instance share one stimulus stream.
module tb_mem_arbiter_nport;
    localparam int NP = 4;
    localparam int BS = 32;
    localparam int LW = BS * 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     reqValid = '0, reqWrite = '0, reqSingle = '0;
    logic [NP*32-1:0]  reqAddr = '0;
    logic [NP*LW-1:0]  reqWdata = '0;
    logic [31:0]       rdata = '0;
    logic              ready = 1'b0;
    logic [LW-1:0]     expLine;
    int errors = 0;
    int checks = 0;
    int bwBeat [10] = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7};
    int bwRdy  [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

    always #5 clk = ~clk;

    mem_arbiter_nport_if #(.NUM_PORTS(NP), .BLOCK_SIZE(BS)) busF ();
    mem_arbiter_nport_if #(.NUM_PORTS(NP), .BLOCK_SIZE(BS)) busR ();

    assign busF.req_valid  = reqValid;
    assign busF.req_write  = reqWrite;
    assign busF.req_single = reqSingle;
    assign busF.req_addr   = reqAddr;
    assign busF.req_wdata  = reqWdata;
    assign busF.rdata      = rdata;
    assign busF.ready      = ready;
    assign busR.req_valid  = reqValid;
    assign busR.req_write  = reqWrite;
    assign busR.req_single = reqSingle;
    assign busR.req_addr   = reqAddr;
    assign busR.req_wdata  = reqWdata;
    assign busR.rdata      = rdata;
    assign busR.ready      = ready;

    mem_arbiter_nport #(.NUM_PORTS(NP), .BLOCK_SIZE(BS), .ARB_MODE(0)) dutF (
        .clk(clk), .rst(rst), .bus(busF)
    );
    mem_arbiter_nport #(.NUM_PORTS(NP), .BLOCK_SIZE(BS), .ARB_MODE(1)) dutR (
        .clk(clk), .rst(rst), .bus(busR)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step(); step();
        chk("rst_grant", busF.grant, 0);
        chk("rst_done", busF.resp_done, 0);
        chk("rst_transfer", busF.transfer, 0);
        chk("rst_addr", busF.addr, 0);
        chk("rst_write", busF.write, 0);
        chk("rst_wdata", busF.wdata, 0);
        chk("rst_rdata", busF.resp_rdata, 0);
        rst = 1'b0;

        // single read, port 2
        reqAddr[64 +: 32] = 32'h4000_0006;
        reqSingle = 4'b0100;
        reqValid  = 4'b0100;
        ready = 1'b1;
        rdata = 32'hDEAD_BEEF;
        step();
        chk("sr_transfer", busF.transfer, 2'b10);
        chk("sr_addr", busF.addr, 32'h4000_0004);
        chk("sr_write", busF.write, 0);
        chk("sr_grant", busF.grant, 4'b0100);
        chk("sr_early_done", busF.resp_done, 0);
        step();
        chk("sr_done", busF.resp_done, 4'b0100);
        chk("sr_rdata", busF.resp_rdata[31:0], 32'hDEAD_BEEF);
        chk("sr_done_idle", busF.transfer, 0);
        reqValid = '0;
        reqSingle = '0;
        step();
        chk("sr_grant_idle", busF.grant, 0);

        // block read, port 0
        reqAddr[0 +: 32] = 32'h0000_1234;
        reqValid = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("br_addr", busF.addr, 32'h1220 + 4 * i);
            chk("br_transfer", busF.transfer, (i == 0) ? 2'b10 : 2'b11);
            rdata = 32'h100 + i;
        end
        step();
        chk("br_done", busF.resp_done, 4'b0001);
        for (int i = 0; i < 8; i++) expLine[32*i +: 32] = 32'h100 + i;
        chk("br_rdata", busF.resp_rdata, expLine);
        reqValid = '0;
        step();

        // block write, port 1, two wait states on beat 3
        for (int i = 0; i < 8; i++) reqWdata[LW + 32*i +: 32] = 32'hA500_0000 + 32'h11 * i;
        reqAddr[32 +: 32] = 32'h2000_0010;
        reqWrite = 4'b0010;
        reqValid = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bw_addr", busF.addr, 32'h2000_0000 + 4 * bwBeat[c]);
            chk("bw_wdata", busF.wdata, 32'hA500_0000 + 32'h11 * bwBeat[c]);
            chk("bw_write", busF.write, 1);
            chk("bw_transfer", busF.transfer, (bwBeat[c] == 0) ? 2'b10 : 2'b11);
            chk("bw_early_done", busF.resp_done, 0);
            ready = bwRdy[c][0];
        end
        ready = 1'b1;
        step();
        chk("bw_done", busF.resp_done, 4'b0010);
        chk("bw_rdata_kept", busF.resp_rdata, expLine);
        reqValid = '0;
        reqWrite = '0;
        step();

        // fixed priority: ports 1 and 3 request continuously
        reqSingle = 4'b1010;
        reqAddr[32 +: 32] = 32'h0000_0300;
        reqAddr[96 +: 32] = 32'h0000_0400;
        reqValid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fp_grant", busF.grant, 4'b0010);
            chk("fp_addr", busF.addr, 32'h300);
            step();
            chk("fp_done", busF.resp_done, 4'b0010);
            step();
            chk("fp_gap", busF.transfer, 0);
        end
        reqValid = '0;
        reqSingle = '0;
        step();

        // reset during beat 4 of a block read on port 3
        reqAddr[96 +: 32] = 32'h8000_0040;
        reqValid = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rs_addr", busF.addr, 32'h8000_0040 + 4 * i);
            chk("rs_no_done", busF.resp_done, 0);
        end
        rst = 1'b1;
        #1;
        chk("rs_transfer", busF.transfer, 0);
        chk("rs_grant", busF.grant, 0);
        step();
        chk("rs_hold_done", busF.resp_done, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rs_re_addr", busF.addr, 32'h8000_0040 + 4 * i);
            chk("rs_re_transfer", busF.transfer, (i == 0) ? 2'b10 : 2'b11);
            chk("rs_re_no_done", busF.resp_done, 0);
        end
        step();
        chk("rs_done", busF.resp_done, 4'b1000);
        reqValid = '0;
        step();

        // port 2 drops req_valid in beat 2
        reqAddr[64 +: 32] = 32'h0000_0500;
        reqValid = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("dr_grant", busF.grant, 4'b0100);
            chk("dr_addr", busF.addr, 32'h500 + 4 * i);
            if (i == 2) reqValid = '0;
        end
        step();
        chk("dr_done", busF.resp_done, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("dr_no_regrant", busF.grant, 0);
            chk("dr_no_done", busF.resp_done, 0);
        end

        // round-robin vs fixed with all four ports requesting
        rst = 1'b1;
        step();
        rst = 1'b0;
        reqSingle = 4'b1111;
        reqValid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_grant", busR.grant, 4'b0001 << (k % 4));
            chk("fp_all_grant", busF.grant, 4'b0001);
            step();
            chk("rr_done", busR.resp_done, 4'b0001 << (k % 4));
            step();
        end
        reqValid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
